// File: rtl/msrv32_alu_arbiter.sv
// Round-robin arbiter sharing one msrv32_alu between two requesters.
// Operands are registered onto the ALU, and the result is buffered per requester one cycle later.
module msrv32_alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,

    input  logic             req0_valid_in,
    output logic             req0_ready_out,
    input  logic [WIDTH-1:0] req0_op1_in,
    input  logic [WIDTH-1:0] req0_op2_in,
    input  logic [OPW-1:0]   req0_opcode_in,
    output logic             rsp0_valid_out,
    input  logic             rsp0_ready_in,
    output logic [WIDTH-1:0] rsp0_result_out,

    input  logic             req1_valid_in,
    output logic             req1_ready_out,
    input  logic [WIDTH-1:0] req1_op1_in,
    input  logic [WIDTH-1:0] req1_op2_in,
    input  logic [OPW-1:0]   req1_opcode_in,
    output logic             rsp1_valid_out,
    input  logic             rsp1_ready_in,
    output logic [WIDTH-1:0] rsp1_result_out,

    output logic [WIDTH-1:0] alu_op1_out,
    output logic [WIDTH-1:0] alu_op2_out,
    output logic [OPW-1:0]   alu_opcode_out,
    input  logic [WIDTH-1:0] alu_result_in,
    output logic             busy_out
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    logic [0:0] state;
    logic       ptr;
    logic       gnt_idx_p0;
    logic       elig0;
    logic       elig1;
    logic       grant0;
    logic       grant1;
    logic       fill0_p1;
    logic       fill1_p1;

    // A full slot blocks its requester even if it is being drained this cycle.
    assign elig0 = req0_valid_in & ~rsp0_valid_out;
    assign elig1 = req1_valid_in & ~rsp1_valid_out;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (elig0 && elig1) begin
                grant0 = ~ptr;
                grant1 = ptr;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign req0_ready_out = grant0;
    assign req1_ready_out = grant1;
    assign busy_out       = (state == EXEC);

    // Stage 0: accept a request and drive the ALU operands.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            gnt_idx_p0     <= 1'b0;
            alu_op1_out    <= '0;
            alu_op2_out    <= '0;
            alu_opcode_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_op1_out    <= grant1 ? req1_op1_in    : req0_op1_in;
                        alu_op2_out    <= grant1 ? req1_op2_in    : req0_op2_in;
                        alu_opcode_out <= grant1 ? req1_opcode_in : req0_opcode_in;
                        gnt_idx_p0     <= grant1;
                        ptr            <= grant0;
                        state          <= EXEC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fill0_p1 = (state == EXEC) && !gnt_idx_p0;
    assign fill1_p1 = (state == EXEC) &&  gnt_idx_p0;

    // Stage 1: capture the ALU result into the owner's response slot.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rsp0_valid_out  <= 1'b0;
            rsp0_result_out <= '0;
        end else if (fill0_p1) begin
            rsp0_valid_out  <= 1'b1;
            rsp0_result_out <= alu_result_in;
        end else if (rsp0_ready_in) begin
            rsp0_valid_out  <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rsp1_valid_out  <= 1'b0;
            rsp1_result_out <= '0;
        end else if (fill1_p1) begin
            rsp1_valid_out  <= 1'b1;
            rsp1_result_out <= alu_result_in;
        end else if (rsp1_ready_in) begin
            rsp1_valid_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_msrv32_alu_arbiter.sv
// Randomized bench for msrv32_alu_arbiter with a behavioural arbiter/ALU model
// and a per-cycle compare process, plus literal scenario checks.
module tb_msrv32_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [OPW-1:0]   req0_opc = '0, req1_opc = '0;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic [WIDTH-1:0] alu_op1, alu_op2, alu_result;
    logic [OPW-1:0]   alu_opc;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msrv32_alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk_in(clk), .rst_in(rst),
        .req0_valid_in(req0_valid), .req0_ready_out(req0_ready),
        .req0_op1_in(req0_op1), .req0_op2_in(req0_op2), .req0_opcode_in(req0_opc),
        .rsp0_valid_out(rsp0_valid), .rsp0_ready_in(rsp0_ready), .rsp0_result_out(rsp0_result),
        .req1_valid_in(req1_valid), .req1_ready_out(req1_ready),
        .req1_op1_in(req1_op1), .req1_op2_in(req1_op2), .req1_opcode_in(req1_opc),
        .rsp1_valid_out(rsp1_valid), .rsp1_ready_in(rsp1_ready), .rsp1_result_out(rsp1_result),
        .alu_op1_out(alu_op1), .alu_op2_out(alu_op2), .alu_opcode_out(alu_opc),
        .alu_result_in(alu_result), .busy_out(busy)
    );

    function automatic logic [WIDTH-1:0] alu_ref(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                                 logic [OPW-1:0] op);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return $unsigned($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return a + b;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_op1, alu_op2, alu_opc);

    task automatic chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who is busy, who owns the ALU, which slots hold what.
    bit               m_busy = 0;
    int               m_idx = 0;
    int               m_ptr = 0;
    bit               m_vld [2] = '{0, 0};
    logic [WIDTH-1:0] m_res [2] = '{32'd0, 32'd0};
    logic [WIDTH-1:0] m_op1 = '0, m_op2 = '0;
    logic [OPW-1:0]   m_opc = '0;

    function automatic int exp_grant();
        bit e [2];
        if (m_busy) return -1;
        e[0] = req0_valid && !m_vld[0];
        e[1] = req1_valid && !m_vld[1];
        if (e[0] && e[1]) return m_ptr;
        if (e[0]) return 0;
        if (e[1]) return 1;
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 0; m_idx = 0; m_ptr = 0;
                m_vld[0] = 0; m_vld[1] = 0;
                m_res[0] = '0; m_res[1] = '0;
                m_op1 = '0; m_op2 = '0; m_opc = '0;
            end else begin
                int g;
                g = exp_grant();
                if (m_vld[0] && rsp0_ready) m_vld[0] = 0;
                if (m_vld[1] && rsp1_ready) m_vld[1] = 0;
                if (m_busy) begin
                    m_vld[m_idx] = 1;
                    m_res[m_idx] = alu_ref(m_op1, m_op2, m_opc);
                    m_busy = 0;
                end else if (g >= 0) begin
                    m_op1  = (g == 1) ? req1_op1 : req0_op1;
                    m_op2  = (g == 1) ? req1_op2 : req0_op2;
                    m_opc  = (g == 1) ? req1_opc : req0_opc;
                    m_idx  = g;
                    m_ptr  = 1 - g;
                    m_busy = 1;
                end
            end
        end
    end

    int               dut_grants [$];
    logic [WIDTH-1:0] dut_cons0 [$];
    logic [WIDTH-1:0] dut_cons1 [$];

    initial begin
        forever begin
            @(negedge clk);
            chk("ready0", req0_ready, (exp_grant() == 0));
            chk("ready1", req1_ready, (exp_grant() == 1));
            chk("busy", busy, m_busy);
            chk("rsp0_valid", rsp0_valid, m_vld[0]);
            chk("rsp1_valid", rsp1_valid, m_vld[1]);
            chk("rsp0_result", rsp0_result, m_res[0]);
            chk("rsp1_result", rsp1_result, m_res[1]);
            chk("alu_op1", alu_op1, m_op1);
            chk("alu_op2", alu_op2, m_op2);
            chk("alu_opcode", alu_opc, m_opc);
            if (!rst) begin
                if (req0_valid && req0_ready) dut_grants.push_back(0);
                if (req1_valid && req1_ready) dut_grants.push_back(1);
                if (rsp0_valid && rsp0_ready) dut_cons0.push_back(rsp0_result);
                if (rsp1_valid && rsp1_ready) dut_cons1.push_back(rsp1_result);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        dut_grants.delete(); dut_cons0.delete(); dut_cons1.delete();
    endtask

    function automatic logic [WIDTH-1:0] qget(logic [WIDTH-1:0] q [$], int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        logic [WIDTH-1:0] h1, h2;
        logic [OPW-1:0]   hop;
        int n0, n1;

        step();
        chk("rst_busy", busy, 0);
        chk("rst_alu_op1", alu_op1, 0);
        chk("rst_alu_opc", alu_opc, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_result", rsp1_result, 0);

        // Single request from requester 0.
        do_reset();
        req0_valid = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd5; req0_opc = 4'b0000;
        #1;
        chk("s1_ready0", req0_ready, 1);
        chk("s1_ready1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        chk("s1_busy", busy, 1);
        chk("s1_alu_op1", alu_op1, 32'd10);
        step();
        chk("s1_rsp0_valid", rsp0_valid, 1);
        chk("s1_rsp0_result", rsp0_result, 32'd15);
        chk("s1_rsp1_valid", rsp1_valid, 0);
        chk("s1_busy_done", busy, 0);
        rsp0_ready = 1'b1;
        step();
        chk("s1_drained", rsp0_valid, 0);
        rsp0_ready = 1'b0;

        // Simultaneous requests right after reset.
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_op1 = 32'd8;    req0_op2 = 32'd3;    req0_opc = 4'b1000;
        req1_valid = 1'b1; req1_op1 = 32'd1234; req1_op2 = 32'd5678; req1_opc = 4'b0111;
        for (int i = 0; i < 20 && dut_grants.size() < 2; i++) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();
        chk("s2_ngrants", dut_grants.size(), 2);
        chk("s2_first", (dut_grants.size() > 0) ? dut_grants[0] : 9, 0);
        chk("s2_second", (dut_grants.size() > 1) ? dut_grants[1] : 9, 1);
        chk("s2_res0", qget(dut_cons0, 0), 32'd5);
        chk("s2_res1", qget(dut_cons1, 0), 32'd1026);
        chk("s2_ptr", m_ptr, 0);

        // Both requesters continuously valid: grants must alternate.
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 60 && dut_grants.size() < 8; i++) begin
            req0_op1 = $urandom; req0_op2 = $urandom; req0_opc = 4'($urandom_range(0, 15));
            req1_op1 = $urandom; req1_op2 = $urandom; req1_opc = 4'($urandom_range(0, 15));
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();
        chk("s3_ngrants", dut_grants.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("s3_alternate", (i < dut_grants.size()) ? dut_grants[i] : 9, i % 2);
        chk("s3_cnt0", dut_cons0.size(), 4);
        chk("s3_cnt1", dut_cons1.size(), 4);

        // Backpressure on requester 0 does not block requester 1.
        do_reset();
        req0_valid = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd5; req0_opc = 4'b0000;
        step(); step();
        chk("s4_rsp0_valid", rsp0_valid, 1);
        req1_valid = 1'b1; req1_op1 = 32'd2; req1_op2 = 32'd2; req1_opc = 4'b0000;
        #1;
        chk("s4_ready0_blocked", req0_ready, 0);
        chk("s4_ready1", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        step();
        chk("s4_rsp1_valid", rsp1_valid, 1);
        chk("s4_rsp1_result", rsp1_result, 32'd4);
        repeat (3) step();
        chk("s4_rsp0_held", rsp0_result, 32'd15);
        chk("s4_rsp0_still", rsp0_valid, 1);
        chk("s4_ready0_still", req0_ready, 0);
        req0_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        step();
        chk("s4_rsp0_drop", rsp0_valid, 0);
        chk("s4_rsp0_keep", rsp0_result, 32'd15);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Asynchronous reset during EXEC drops everything at once.
        do_reset();
        req1_valid = 1'b1; req1_op1 = 32'd3; req1_op2 = 32'd4; req1_opc = 4'b0000;
        step();
        req1_valid = 1'b0;
        step();
        chk("s5_rsp1_buffered", rsp1_valid, 1);
        req0_valid = 1'b1; req0_op1 = 32'd7; req0_op2 = 32'd1; req0_opc = 4'b0000;
        step();
        req0_valid = 1'b0;
        chk("s5_in_exec", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("s5_busy_async", busy, 0);
        chk("s5_rsp0_async", rsp0_valid, 0);
        chk("s5_rsp1_async", rsp1_valid, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s5_no_ghost", rsp0_valid, 0);
        end

        // Idle: nothing moves.
        h1 = alu_op1; h2 = alu_op2; hop = alu_opc;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("s6_ready0", req0_ready, 0);
            chk("s6_busy", busy, 0);
            chk("s6_alu_op1", alu_op1, h1);
            chk("s6_alu_op2", alu_op2, h2);
            chk("s6_alu_opc", alu_opc, hop);
        end

        // Random traffic with occasional mid-cycle resets.
        n0 = 0; n1 = 0;
        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_op1 = $urandom; req0_op2 = $urandom; req0_opc = 4'($urandom_range(0, 15));
            req1_op1 = $urandom; req1_op2 = $urandom; req1_opc = 4'($urandom_range(0, 15));
            rsp0_ready = ($urandom_range(0, 1) != 0);
            rsp1_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
            if (req0_ready) n0++;
            if (req1_ready) n1++;
        end
        checks++;
        if (n0 == 0 || n1 == 0) begin
            errors++;
            $display("FAIL rand_activity: ready counts %0d/%0d required both nonzero", n0, n1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
